// File: rtl/axi_lite_bram_responder_if.sv
// AXI4-Lite bus bundle between the core/UART address router (master) and the
// BRAM responder (slave).
interface axi_lite_bram_responder_if;
   logic [31:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] axi_awaddr;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;

   modport slave (
      input  axi_araddr, axi_arvalid, axi_rready,
      input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
      output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
      output axi_awready, axi_wready, axi_bresp, axi_bvalid
   );

   modport master (
      output axi_araddr, axi_arvalid, axi_rready,
      output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
      input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
      input  axi_awready, axi_wready, axi_bresp, axi_bvalid
   );
endinterface

// File: rtl/axi_lite_bram_responder.sv
// AXI4-Lite responder over a 32-bit block RAM. Read and write channels are
// independent FSMs sharing one array; reads see pre-write data on a collision.
module axi_lite_bram_responder #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter string       INIT_FILE  = ""
) (
   input logic                      clk,
   input logic                      rstn,
   axi_lite_bram_responder_if.slave axi
);

   localparam int unsigned IdxW  = ADDR_WIDTH - 2;
   localparam int unsigned Depth = 2 ** IdxW;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlvErr = 2'b10;

   typedef enum logic {StRIdle, StRResp} r_state_e;
   typedef enum logic {StWIdle, StWResp} w_state_e;

   logic [31:0] mem [Depth];

   function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
      return addr[ADDR_WIDTH-1:2];
   endfunction

   // Shift rather than slice so ADDR_WIDTH=32 still elaborates.
   function automatic logic out_of_range(input logic [31:0] addr);
      return (addr >> ADDR_WIDTH) != 32'd0;
   endfunction

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{axi.axi_araddr[1:0], axi.axi_awaddr[1:0]};

   // ---------------------------------------------------------------- read
   r_state_e    r_state_q;
   logic        arready_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic        ar_hs;

   assign ar_hs = axi.axi_arvalid & arready_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state_q <= StRIdle;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= RespOkay;
      end else begin
         unique case (r_state_q)
            StRIdle: begin
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  r_state_q <= StRResp;
                  // mem is updated by non-blocking writes, so this is the old word.
                  if (out_of_range(axi.axi_araddr)) begin
                     rdata_q <= 32'd0;
                     rresp_q <= RespSlvErr;
                  end else begin
                     rdata_q <= mem[word_idx(axi.axi_araddr)];
                     rresp_q <= RespOkay;
                  end
               end
            end
            StRResp: begin
               if (axi.axi_rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state_q <= StRIdle;
               end
            end
         endcase
      end
   end

   assign axi.axi_arready = arready_q;
   assign axi.axi_rvalid  = rvalid_q;
   assign axi.axi_rdata   = rdata_q;
   assign axi.axi_rresp   = rresp_q;

   // --------------------------------------------------------------- write
   w_state_e    w_state_q;
   logic        awready_q;
   logic        wready_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;
   logic [31:0] awaddr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;

   logic        aw_hs;
   logic        w_hs;
   logic        have_aw;
   logic        have_w;
   logic        commit;
   logic [31:0] cm_addr;
   logic [31:0] cm_data;
   logic [3:0]  cm_strb;
   logic        cm_oor;

   // A half is "held" when it arrives now or was latched earlier (ready low in idle).
   always_comb begin
      aw_hs   = axi.axi_awvalid & awready_q;
      w_hs    = axi.axi_wvalid & wready_q;
      have_aw = aw_hs | ((w_state_q == StWIdle) & ~awready_q);
      have_w  = w_hs | ((w_state_q == StWIdle) & ~wready_q);
      commit  = (w_state_q == StWIdle) & have_aw & have_w;
      cm_addr = aw_hs ? axi.axi_awaddr : awaddr_q;
      cm_data = w_hs ? axi.axi_wdata : wdata_q;
      cm_strb = w_hs ? axi.axi_wstrb : wstrb_q;
      cm_oor  = out_of_range(cm_addr);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_q <= StWIdle;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= RespOkay;
         awaddr_q  <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
      end else begin
         unique case (w_state_q)
            StWIdle: begin
               if (commit) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= cm_oor ? RespSlvErr : RespOkay;
                  w_state_q <= StWResp;
               end else begin
                  if (aw_hs) begin
                     awaddr_q  <= axi.axi_awaddr;
                     awready_q <= 1'b0;
                  end
                  if (w_hs) begin
                     wdata_q  <= axi.axi_wdata;
                     wstrb_q  <= axi.axi_wstrb;
                     wready_q <= 1'b0;
                  end
               end
            end
            StWResp: begin
               if (axi.axi_bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state_q <= StWIdle;
               end
            end
         endcase
      end
   end

   // Commit edge is the only RAM write; gated by rstn so reset never writes.
   always_ff @(posedge clk) begin
      if (rstn && commit && !cm_oor) begin
         for (int i = 0; i < 4; i++) begin
            if (cm_strb[i]) begin
               mem[word_idx(cm_addr)][8*i +: 8] <= cm_data[8*i +: 8];
            end
         end
      end
   end

   assign axi.axi_awready = awready_q;
   assign axi.axi_wready  = wready_q;
   assign axi.axi_bvalid  = bvalid_q;
   assign axi.axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_bram_responder.sv
// Directed bench for axi_lite_bram_responder: handshakes, strobes, backpressure,
// read/write collision, out-of-range, throughput and asynchronous reset.
module tb_axi_lite_bram_responder;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   axi_lite_bram_responder_if bus ();

   axi_lite_bram_responder #(
      .ADDR_WIDTH(14),
      .INIT_FILE ("")
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .axi (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp, output int lat);
      int n;
      @(negedge clk);
      bus.axi_awaddr  = addr;
      bus.axi_wdata   = data;
      bus.axi_wstrb   = strb;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid  = 1'b1;
      bus.axi_bready  = 1'b0;
      n = 0;
      while (!(bus.axi_awready && bus.axi_wready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
      lat = 1;
      while (!bus.axi_bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.axi_bvalid) lat = -1;
      resp = bus.axi_bresp;
      bus.axi_bready = 1'b1;
      @(negedge clk);
      bus.axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
      int n;
      @(negedge clk);
      bus.axi_araddr  = addr;
      bus.axi_arvalid = 1'b1;
      bus.axi_rready  = 1'b0;
      n = 0;
      while (!bus.axi_arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.axi_arvalid = 1'b0;
      lat = 1;
      while (!bus.axi_rvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.axi_rvalid) lat = -1;
      data = bus.axi_rdata;
      resp = bus.axi_rresp;
      bus.axi_rready = 1'b1;
      @(negedge clk);
      bus.axi_rready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      bus.axi_araddr = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;
      bus.axi_awaddr = '0; bus.axi_awvalid = 1'b0; bus.axi_wdata = '0;
      bus.axi_wstrb = '0; bus.axi_wvalid = 1'b0; bus.axi_bready = 1'b0;
      #1 rstn = 1'b0;
      #1;
      checks++;
      if ({bus.axi_arready, bus.axi_awready, bus.axi_wready} !== 3'b111) begin
         failures++;
         $display("FAIL reset_readys: got %b expected 111",
                  {bus.axi_arready, bus.axi_awready, bus.axi_wready});
      end
      checks++;
      if ({bus.axi_rvalid, bus.axi_bvalid, bus.axi_rresp, bus.axi_bresp} !== 6'b0) begin
         failures++;
         $display("FAIL reset_valid_resp: got %b expected 000000",
                  {bus.axi_rvalid, bus.axi_bvalid, bus.axi_rresp, bus.axi_bresp});
      end
      checks++;
      if (bus.axi_rdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 00000000", bus.axi_rdata);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_write_read_same_cycle();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      @(negedge clk);
      bus.axi_awaddr = 32'h10; bus.axi_wdata = 32'hDEADBEEF; bus.axi_wstrb = 4'hF;
      bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_bready = 1'b0;
      @(negedge clk);
      bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
      checks++;
      if ({bus.axi_bvalid, bus.axi_bresp, bus.axi_awready, bus.axi_wready} !== 5'b10000) begin
         failures++;
         $display("FAIL wr1_bvalid_next_cycle: got %b expected 10000",
                  {bus.axi_bvalid, bus.axi_bresp, bus.axi_awready, bus.axi_wready});
      end
      bus.axi_bready = 1'b1;
      @(negedge clk);
      bus.axi_bready = 1'b0;
      checks++;
      if ({bus.axi_bvalid, bus.axi_awready, bus.axi_wready} !== 3'b011) begin
         failures++;
         $display("FAIL wr1_b_accept: got %b expected 011",
                  {bus.axi_bvalid, bus.axi_awready, bus.axi_wready});
      end
      axi_read(32'h10, d, r, lat);
      checks++;
      if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 1) begin
         failures++;
         $display("FAIL rd1: got data=%h resp=%b lat=%0d expected DEADBEEF 00 1", d, r, lat);
      end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      @(negedge clk);
      bus.axi_wdata = 32'h0000AA00; bus.axi_wstrb = 4'b0010; bus.axi_wvalid = 1'b1;
      @(negedge clk);
      bus.axi_wvalid = 1'b0;
      checks++;
      if ({bus.axi_wready, bus.axi_awready} !== 2'b01) begin
         failures++;
         $display("FAIL w_first_readys: got %b expected 01", {bus.axi_wready, bus.axi_awready});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.axi_bvalid !== 1'b0) begin
            failures++;
            $display("FAIL w_first_no_bvalid: cycle %0d got %b expected 0", i, bus.axi_bvalid);
         end
      end
      bus.axi_awaddr = 32'h10; bus.axi_awvalid = 1'b1;
      @(negedge clk);
      bus.axi_awvalid = 1'b0;
      checks++;
      if ({bus.axi_bvalid, bus.axi_bresp} !== 3'b100) begin
         failures++;
         $display("FAIL aw_late_bvalid: got %b expected 100", {bus.axi_bvalid, bus.axi_bresp});
      end
      bus.axi_bready = 1'b1;
      @(negedge clk);
      bus.axi_bready = 1'b0;
      axi_read(32'h10, d, r, lat);
      checks++;
      if (d !== 32'hDEADAAEF || r !== 2'b00) begin
         failures++;
         $display("FAIL strb_0010_merge: got %h/%b expected DEADAAEF/00", d, r);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      @(negedge clk);
      bus.axi_awaddr = 32'h20; bus.axi_wdata = 32'hCAFEF00D; bus.axi_wstrb = 4'hF;
      bus.axi_araddr = 32'h10;
      bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_arvalid = 1'b1;
      bus.axi_bready = 1'b0; bus.axi_rready = 1'b0;
      @(negedge clk);
      // Offer a second transaction on every channel while the first is stalled.
      bus.axi_awaddr = 32'h24; bus.axi_wdata = 32'h11111111; bus.axi_araddr = 32'h20;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.axi_bvalid, bus.axi_rvalid, bus.axi_bresp, bus.axi_rresp} !== 6'b110000 ||
             bus.axi_rdata !== 32'hDEADAAEF) begin
            failures++;
            $display("FAIL bp_hold: cycle %0d got v=%b%b resp=%b%b data=%h expected 11 0000 DEADAAEF",
                     i, bus.axi_bvalid, bus.axi_rvalid, bus.axi_bresp, bus.axi_rresp, bus.axi_rdata);
         end
         checks++;
         if ({bus.axi_arready, bus.axi_awready, bus.axi_wready} !== 3'b000) begin
            failures++;
            $display("FAIL bp_refuse: cycle %0d got %b expected 000",
                     i, {bus.axi_arready, bus.axi_awready, bus.axi_wready});
         end
      end
      bus.axi_bready = 1'b1; bus.axi_rready = 1'b1;
      @(negedge clk);
      bus.axi_bready = 1'b0; bus.axi_rready = 1'b0;
      checks++;
      if ({bus.axi_bvalid, bus.axi_rvalid, bus.axi_arready, bus.axi_awready, bus.axi_wready}
          !== 5'b00111) begin
         failures++;
         $display("FAIL bp_release: got %b expected 00111",
                  {bus.axi_bvalid, bus.axi_rvalid, bus.axi_arready, bus.axi_awready, bus.axi_wready});
      end
      @(negedge clk);
      bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
      checks++;
      if ({bus.axi_bvalid, bus.axi_rvalid} !== 2'b11 || bus.axi_rdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL bp_second_txn: got v=%b%b data=%h expected 11 CAFEF00D",
                  bus.axi_bvalid, bus.axi_rvalid, bus.axi_rdata);
      end
      bus.axi_bready = 1'b1; bus.axi_rready = 1'b1;
      @(negedge clk);
      bus.axi_bready = 1'b0; bus.axi_rready = 1'b0;
      axi_read(32'h24, d, r, lat);
      checks++;
      if (d !== 32'h11111111) begin
         failures++;
         $display("FAIL bp_second_write: got %h expected 11111111", d);
      end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      @(negedge clk);
      bus.axi_araddr = 32'h10; bus.axi_awaddr = 32'h10;
      bus.axi_wdata = 32'h12345678; bus.axi_wstrb = 4'hF;
      bus.axi_arvalid = 1'b1; bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1;
      @(negedge clk);
      bus.axi_arvalid = 1'b0; bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
      checks++;
      if (bus.axi_rvalid !== 1'b1 || bus.axi_rdata !== 32'hDEADAAEF) begin
         failures++;
         $display("FAIL collision_old_data: got v=%b data=%h expected 1 DEADAAEF",
                  bus.axi_rvalid, bus.axi_rdata);
      end
      bus.axi_bready = 1'b1; bus.axi_rready = 1'b1;
      @(negedge clk);
      bus.axi_bready = 1'b0; bus.axi_rready = 1'b0;
      axi_read(32'h10, d, r, lat);
      checks++;
      if (d !== 32'h12345678) begin
         failures++;
         $display("FAIL collision_new_data: got %h expected 12345678", d);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      axi_write(32'h0, 32'h0BADC0DE, 4'hF, r, lat);
      axi_write(32'h0001_0000, 32'hFFFFFFFF, 4'hF, r, lat);
      checks++;
      if (r !== 2'b10 || lat !== 1) begin
         failures++;
         $display("FAIL oor_write_resp: got resp=%b lat=%0d expected 10 1", r, lat);
      end
      axi_read(32'h0, d, r, lat);
      checks++;
      if (d !== 32'h0BADC0DE) begin
         failures++;
         $display("FAIL oor_ram_unchanged: got %h expected 0BADC0DE", d);
      end
      axi_read(32'h0001_0000, d, r, lat);
      checks++;
      if (d !== 32'd0 || r !== 2'b10) begin
         failures++;
         $display("FAIL oor_read: got %h/%b expected 00000000/10", d, r);
      end
   endtask

   task automatic test_strb_zero();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      axi_write(32'h10, 32'hFFFFFFFF, 4'b0000, r, lat);
      checks++;
      if (r !== 2'b00) begin
         failures++;
         $display("FAIL strb0_resp: got %b expected 00", r);
      end
      axi_read(32'h11, d, r, lat);
      checks++;
      if (d !== 32'h12345678) begin
         failures++;
         $display("FAIL strb0_data: got %h expected 12345678", d);
      end
   endtask

   task automatic test_back_to_back();
      int hs;
      int rsp;
      @(negedge clk);
      bus.axi_awaddr = 32'h30; bus.axi_wdata = 32'h5A5A0000; bus.axi_wstrb = 4'hF;
      bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_bready = 1'b1;
      hs = 0; rsp = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.axi_awready && bus.axi_wready) hs++;
         if (bus.axi_bvalid) rsp++;
         @(negedge clk);
      end
      bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
      @(negedge clk);
      bus.axi_bready = 1'b0;
      checks++;
      if (hs !== 4 || rsp !== 4) begin
         failures++;
         $display("FAIL b2b_write: got hs=%0d rsp=%0d expected 4 4", hs, rsp);
      end
      bus.axi_araddr = 32'h30; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b1;
      hs = 0; rsp = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.axi_arready) hs++;
         if (bus.axi_rvalid && bus.axi_rdata === 32'h5A5A0000) rsp++;
         @(negedge clk);
      end
      bus.axi_arvalid = 1'b0;
      @(negedge clk);
      bus.axi_rready = 1'b0;
      checks++;
      if (hs !== 4 || rsp !== 4) begin
         failures++;
         $display("FAIL b2b_read: got hs=%0d rsp=%0d expected 4 4", hs, rsp);
      end
   endtask

   task automatic test_reset_mid_txn();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      @(negedge clk);
      bus.axi_awaddr = 32'h40; bus.axi_awvalid = 1'b1;
      bus.axi_araddr = 32'h10; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b0;
      @(negedge clk);
      bus.axi_awvalid = 1'b0; bus.axi_arvalid = 1'b0;
      checks++;
      if ({bus.axi_awready, bus.axi_rvalid} !== 2'b01) begin
         failures++;
         $display("FAIL mid_setup: got %b expected 01", {bus.axi_awready, bus.axi_rvalid});
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({bus.axi_arready, bus.axi_awready, bus.axi_wready, bus.axi_rvalid, bus.axi_bvalid}
          !== 5'b11100 || bus.axi_rdata !== 32'd0) begin
         failures++;
         $display("FAIL mid_async_reset: got %b data=%h expected 11100 00000000",
                  {bus.axi_arready, bus.axi_awready, bus.axi_wready, bus.axi_rvalid, bus.axi_bvalid},
                  bus.axi_rdata);
      end
      @(negedge clk);
      rstn = 1'b1;
      bus.axi_wdata = 32'hA5A5A5A5; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
      @(negedge clk);
      bus.axi_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.axi_bvalid, bus.axi_awready, bus.axi_wready} !== 3'b010) begin
            failures++;
            $display("FAIL mid_w_alone: cycle %0d got %b expected 010",
                     i, {bus.axi_bvalid, bus.axi_awready, bus.axi_wready});
         end
         @(negedge clk);
      end
      bus.axi_awaddr = 32'h40; bus.axi_awvalid = 1'b1;
      @(negedge clk);
      bus.axi_awvalid = 1'b0;
      checks++;
      if (bus.axi_bvalid !== 1'b1) begin
         failures++;
         $display("FAIL mid_aw_completes: got %b expected 1", bus.axi_bvalid);
      end
      bus.axi_bready = 1'b1;
      @(negedge clk);
      bus.axi_bready = 1'b0;
      axi_read(32'h40, d, r, lat);
      checks++;
      if (d !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL mid_readback: got %h expected A5A5A5A5", d);
      end
      axi_read(32'h10, d, r, lat);
      checks++;
      if (d !== 32'h12345678) begin
         failures++;
         $display("FAIL ram_survives_reset: got %h expected 12345678", d);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_write_read_same_cycle();
      test_w_before_aw();
      test_backpressure();
      test_collision();
      test_out_of_range();
      test_strb_zero();
      test_back_to_back();
      test_reset_mid_txn();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
